alu_accum_seq: RTL and testbench

Parametrised sequential ALU with a 2N-bit accumulator and a start/busy/done handshake. It succeeds the single-cycle breadboard datapath:

- Operand width is a parameter.
- MUL and DIV are iterative (shift-add and restoring, one bit per cycle).
- Overflow, divide-by-zero and zero flags are registered.
- The B operand can be taken from the accumulator, so operations can be chained.

It sits between the operand registers and the accumulator readout in the ALU top level.

---
 rtl/alu_accum_seq_if.sv | 27 ++
 rtl/alu_accum_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_accum_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_accum_seq_if.sv
// Handshake and data bundle between the operand registers and alu_accum_seq.
// The master drives requests; the slave (the ALU) drives status and the accumulator.
interface alu_accum_seq_if #(
    parameter int unsigned N = 16
);
    logic           start;
    logic [3:0]     cmd;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           use_acc;
    logic           busy;
    logic           done;
    logic [2*N-1:0] acc_out;
    logic           overflow;
    logic           div_by_zero;
    logic           zero;

    modport master (
        output start, cmd, a, b, use_acc,
        input  busy, done, acc_out, overflow, div_by_zero, zero
    );

    modport slave (
        input  start, cmd, a, b, use_acc,
        output busy, done, acc_out, overflow, div_by_zero, zero
    );
endinterface

// File: rtl/alu_accum_seq.sv
// Sequential ALU with a 2N-bit accumulator: single-cycle logic/add ops plus
// iterative shift-add MUL and restoring DIV sharing one {hi, lo} work register.
module alu_accum_seq #(
    parameter int unsigned N = 16
) (
    input logic              clk,
    input logic              rst,
    alu_accum_seq_if.slave   bus
);
    localparam int unsigned  CntW    = $clog2(N);
    localparam logic [N-1:0] ShLimit = N'(2 * N);

    localparam logic [3:0] OpNop  = 4'd0,  OpAdd  = 4'd1,  OpSub  = 4'd2,  OpMul = 4'd3;
    localparam logic [3:0] OpDiv  = 4'd4,  OpSrl  = 4'd5,  OpSll  = 4'd6,  OpAnd = 4'd7;
    localparam logic [3:0] OpOr   = 4'd8,  OpXor  = 4'd9,  OpNot  = 4'd10, OpNand = 4'd11;
    localparam logic [3:0] OpNor  = 4'd12, OpXnor = 4'd13, OpAcc  = 4'd14, OpClr = 4'd15;

    typedef enum logic [1:0] {StIdle, StExec, StIter} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;

    logic [N-1:0]    b_sel;
    logic [N:0]      sum_add;
    logic [2*N:0]    sum_acc;
    logic [N:0]      mul_sum;
    logic [N:0]      div_sh;
    logic [N-1:0]    div_diff;
    logic            div_ge;
    logic [N-1:0]    step_hi;
    logic [N-1:0]    step_lo;
    logic            wr;

    always_comb begin
        b_sel    = bus.use_acc ? acc_q[N-1:0] : bus.b;
        sum_add  = {1'b0, a_q} + {1'b0, b_q};
        sum_acc  = {1'b0, acc_q} + {{(N + 1){1'b0}}, a_q};
        // MUL: conditionally add B into hi, then shift {carry, hi, lo} right by one
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N + 1){1'b0}});
        // DIV: shift next dividend bit into remainder, subtract B if it fits
        div_sh   = {hi_q, lo_q[N-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        div_diff = div_sh[N-1:0] - b_q;
        if (cmd_q == OpMul) begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_q[N-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_sh[N-1:0];
            step_lo = {lo_q[N-2:0], div_ge};
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        wr      = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cmd_d = bus.cmd;
                    a_d   = bus.a;
                    b_d   = b_sel;
                    hi_d  = '0;
                    lo_d  = bus.a;
                    cnt_d = '0;
                    if ((bus.cmd == OpMul || bus.cmd == OpDiv) && b_sel != '0) begin
                        state_d = StIter;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                state_d = StIdle;
                done_d  = 1'b1;
                wr      = 1'b1;
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
                unique case (cmd_q)
                    OpNop:  wr = 1'b0;
                    OpAdd: begin
                        acc_d = {{(N - 1){1'b0}}, sum_add};
                        ovf_d = sum_add[N];
                    end
                    OpSub: begin
                        acc_d = {{N{1'b0}}, a_q - b_q};
                        ovf_d = a_q < b_q;
                    end
                    // Only reached here with B == 0
                    OpMul:  acc_d = '0;
                    OpDiv: begin
                        acc_d = {a_q, {N{1'b1}}};
                        dbz_d = 1'b1;
                    end
                    OpSrl:  acc_d = (b_q >= ShLimit) ? '0 : ({{N{1'b0}}, a_q} >> b_q);
                    OpSll:  acc_d = (b_q >= ShLimit) ? '0 : ({{N{1'b0}}, a_q} << b_q);
                    OpAnd:  acc_d = {{N{1'b0}}, a_q & b_q};
                    OpOr:   acc_d = {{N{1'b0}}, a_q | b_q};
                    OpXor:  acc_d = {{N{1'b0}}, a_q ^ b_q};
                    OpNot:  acc_d = {{N{1'b0}}, ~a_q};
                    OpNand: acc_d = {{N{1'b0}}, ~(a_q & b_q)};
                    OpNor:  acc_d = {{N{1'b0}}, ~(a_q | b_q)};
                    OpXnor: acc_d = {{N{1'b0}}, ~(a_q ^ b_q)};
                    OpAcc: begin
                        acc_d = sum_acc[2*N-1:0];
                        ovf_d = sum_acc[2*N];
                    end
                    OpClr:  acc_d = '0;
                endcase
                if (!wr) begin
                    ovf_d = ovf_q;
                    dbz_d = dbz_q;
                end
            end
            StIter: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    wr      = 1'b1;
                    acc_d   = {step_hi, step_lo};
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr) begin
            zero_d = (acc_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.acc_out     = acc_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq: expected results queued at issue time and
// compared when done is observed.
module tb_alu_accum_seq;
    localparam int unsigned N = 16;

    localparam logic [3:0] OpNop = 4'd0,  OpAdd = 4'd1,  OpSub = 4'd2,  OpMul = 4'd3;
    localparam logic [3:0] OpDiv = 4'd4,  OpSrl = 4'd5,  OpSll = 4'd6,  OpXor = 4'd9;
    localparam logic [3:0] OpNand = 4'd11, OpAcc = 4'd14, OpClr = 4'd15;

    typedef struct {
        string       tag;
        logic [31:0] acc;
        logic        ovf;
        logic        dbz;
        logic        zero;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [31:0] last_acc;

    alu_accum_seq_if #(.N(N)) bus ();

    alu_accum_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] acc, input logic ovf,
                        input logic dbz, input logic zero, input int lat);
        exp_t e;
        e.tag = tag; e.acc = acc; e.ovf = ovf; e.dbz = dbz; e.zero = zero; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns just after the capture edge.
    task automatic start_op(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                            input logic use_acc);
        bus.cmd = cmd; bus.a = a; bus.b = b; bus.use_acc = use_acc; bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_capture", 64'(bus.busy), 64'd1);
        bus.start   = 1'b0;
        bus.cmd     = 4'($urandom_range(0, 15));
        bus.a       = 16'($urandom);
        bus.b       = 16'($urandom);
        bus.use_acc = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int poke_at);
        exp_t e;
        int   cyc;
        bit   seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("acc_held_first_cycle", 64'(bus.acc_out), 64'(last_acc));
                chk("done_low_first_cycle", 64'(bus.done), 64'd0);
            end
            bus.start = 1'b0;
            if (cyc == poke_at) begin
                bus.cmd = OpAdd; bus.a = 16'd1; bus.b = 16'd1; bus.use_acc = 1'b0;
                bus.start = 1'b1;
            end
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_latency"}, 64'(cyc), 64'(e.lat + 1));
            chk({e.tag, "_acc"}, 64'(bus.acc_out), 64'(e.acc));
            chk({e.tag, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
            chk({e.tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
            chk({e.tag, "_zero"}, 64'(bus.zero), 64'(e.zero));
            chk({e.tag, "_busy_low"}, 64'(bus.busy), 64'd0);
            last_acc = e.acc;
        end
    endtask

    task automatic op(input string tag, input logic [3:0] cmd, input logic [15:0] a,
                      input logic [15:0] b, input logic use_acc, input logic [31:0] acc,
                      input logic ovf, input logic dbz, input logic zero, input int lat);
        push(tag, acc, ovf, dbz, zero, lat);
        start_op(cmd, a, b, use_acc);
        wait_done(0);
    endtask

    initial begin
        int extra;
        checks = 0;
        errors = 0;
        last_acc = 32'd0;
        bus.start = 1'b0; bus.cmd = 4'd0; bus.a = '0; bus.b = '0; bus.use_acc = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_acc", 64'(bus.acc_out), 64'd0);
        chk("reset_flags", {61'd0, bus.overflow, bus.div_by_zero, bus.zero}, 64'd1);
        chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        op("add_17_15", OpAdd, 16'd17, 16'd15, 1'b0, 32'd32, 1'b0, 1'b0, 1'b0, 1);
        op("add_carry", OpAdd, 16'hFFFF, 16'd1, 1'b0, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1);
        op("sub_borrow", OpSub, 16'd3, 16'd5, 1'b0, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0, 1);

        // MUL with a start poke mid-operation that must be ignored
        push("mul_max", 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, N);
        start_op(OpMul, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(5);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("mul_single_done", 64'(extra), 64'd0);
        chk("mul_acc_stable", 64'(bus.acc_out), 64'h0000_0000_FFFE_0001);

        op("div_100_7", OpDiv, 16'd100, 16'd7, 1'b0, 32'h0002_000E, 1'b0, 1'b0, 1'b0, N);
        op("div_by_0", OpDiv, 16'd9, 16'd0, 1'b0, 32'h0009_FFFF, 1'b0, 1'b1, 1'b0, 1);
        op("add_clr_dbz", OpAdd, 16'd1, 16'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1);

        op("clr", OpClr, 16'h1234, 16'h5678, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1);
        op("accadd_1", OpAcc, 16'd5, 16'd0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1);
        op("accadd_2", OpAcc, 16'd5, 16'd0, 1'b0, 32'd10, 1'b0, 1'b0, 1'b0, 1);
        op("accadd_3", OpAcc, 16'd5, 16'd0, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0, 1);
        op("add_use_acc", OpAdd, 16'd1, 16'h1234, 1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 1);

        op("sll_16", OpSll, 16'hFFFF, 16'd16, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1);
        op("accadd_fill", OpAcc, 16'hFFFF, 16'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
        op("accadd_wrap", OpAcc, 16'd1, 16'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        op("nop_hold", OpNop, 16'h00AA, 16'h0055, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1);

        op("xor", OpXor, 16'hF0F0, 16'hFF00, 1'b0, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 1);
        op("nand", OpNand, 16'hF0F0, 16'hFF00, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1);
        op("srl_3", OpSrl, 16'h8000, 16'd3, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1);
        op("srl_32", OpSrl, 16'h8000, 16'd32, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1);
        op("sll_31", OpSll, 16'd1, 16'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1);
        op("sll_32", OpSll, 16'd1, 16'd32, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1);
        op("mul_small", OpMul, 16'd300, 16'd7, 1'b0, 32'd2100, 1'b0, 1'b0, 1'b0, N);
        op("add_pre_rst", OpAdd, 16'hFFFF, 16'd2, 1'b0, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 1);

        // Abort a MUL with reset in its fifth cycle
        start_op(OpMul, 16'd1234, 16'd567, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_acc", 64'(bus.acc_out), 64'd0);
        chk("abort_flags", {61'd0, bus.overflow, bus.div_by_zero, bus.zero}, 64'd1);
        chk("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_acc = 32'd0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'd0);
        op("add_after_rst", OpAdd, 16'd2, 16'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0, 1);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
